// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Flag indices match the ALUFlags layout used by cond_logic.
package mcycle_unit_pkg;

  typedef enum logic [1:0] {
    OP_UMUL = 2'b00,
    OP_SMUL = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } mcop_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COMPUTE = 2'b01,
    S_DONE    = 2'b10
  } mcstate_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/mcycle_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one
// 2*WIDTH shift register and one WIDTH+1 adder; stalls via Busy.
module mcycle_unit
  import mcycle_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       MFlags,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] condNeg(
    input logic [WIDTH-1:0] x,
    input logic             neg
  );
    return neg ? (~x + WIDTH'(1)) : x;
  endfunction

  mcstate_e          state;
  mcstate_e          stateNext;
  logic [1:0]        op;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [WIDTH-1:0]  mag2;
  logic [W2-1:0]     sr;
  logic [W2-1:0]     srNext;
  logic [CW-1:0]     count;

  logic              isDiv;
  logic              isSigned;
  logic              lastStep;
  logic              latch;
  logic [WIDTH:0]    addA;
  logic [WIDTH:0]    addB;
  logic [WIDTH:0]    sum;
  logic              borrow;

  logic [W2-1:0]     prod;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic              divZero;
  logic              divOvf;
  logic [WIDTH-1:0]  fin1;
  logic [WIDTH-1:0]  fin2;
  logic [3:0]        finFlags;

  assign isDiv    = op[1];
  assign isSigned = op[0];
  assign lastStep = (count == CW'(WIDTH - 1));
  assign latch    = (state == S_IDLE) && Start;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:    if (Start) stateNext = S_COMPUTE;
      S_COMPUTE: if (lastStep) stateNext = S_DONE;
      S_DONE:    stateNext = S_IDLE;
      default:   stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = latch || (state == S_COMPUTE);
  end

  // Div: addA = {rem, next dividend bit}; subtract via ~d + 1.
  always_comb begin
    addA   = isDiv ? sr[W2-1:WIDTH-1]
                   : {1'b0, sr[W2-1:WIDTH]};
    addB   = isDiv ? ~{1'b0, mag2}
                   : (sr[0] ? {1'b0, mag2} : '0);
    sum    = addA + addB + {{WIDTH{1'b0}}, isDiv};
    borrow = sum[WIDTH];
    if (isDiv)
      srNext = {borrow ? addA[WIDTH-1:0] : sum[WIDTH-1:0],
                sr[WIDTH-2:0], ~borrow};
    else
      srNext = {sum, sr[WIDTH-1:1]};
  end

  always_comb begin
    prod     = srNext;
    if (isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]))
      prod   = ~srNext + W2'(1);
    quo      = condNeg(srNext[WIDTH-1:0],
                 isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]));
    rem      = condNeg(srNext[W2-1:WIDTH],
                 isSigned && opA[WIDTH-1]);
    divZero  = (opB == '0);
    divOvf   = isSigned && (opA == {1'b1, {(WIDTH-1){1'b0}}})
               && (opB == '1);
    finFlags = '0;
    if (isDiv) begin
      fin1 = divZero ? '1 : quo;
      fin2 = divZero ? opA : rem;
      finFlags[FLAG_N] = fin1[WIDTH-1];
      finFlags[FLAG_Z] = (fin1 == '0);
      finFlags[FLAG_V] = divZero || divOvf;
    end else begin
      fin1 = prod[WIDTH-1:0];
      fin2 = prod[W2-1:WIDTH];
      finFlags[FLAG_N] = prod[W2-1];
      finFlags[FLAG_Z] = (prod == '0);
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      op    <= '0;
      opA   <= '0;
      opB   <= '0;
      mag2  <= '0;
      sr    <= '0;
      count <= '0;
    end else if (latch) begin
      op    <= MCycleOp;
      opA   <= Operand1;
      opB   <= Operand2;
      mag2  <= condNeg(Operand2,
                 MCycleOp[0] && Operand2[WIDTH-1]);
      sr    <= {{WIDTH{1'b0}}, condNeg(Operand1,
                 MCycleOp[0] && Operand1[WIDTH-1])};
      count <= '0;
    end else if (state == S_COMPUTE) begin
      sr    <= srNext;
      count <= count + CW'(1);
    end
  end

  // Results land on the edge into DONE so the stalled op reads them there.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      Result1 <= '0;
      Result2 <= '0;
      MFlags  <= '0;
    end else if (state == S_COMPUTE && lastStep) begin
      Result1 <= fin1;
      Result2 <= fin2;
      MFlags  <= finFlags;
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed and exhaustive checks for mcycle_unit at WIDTH=32 and
// WIDTH=4, including stall length, Start handling and async reset.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [31:0] res1;
  logic [31:0] res2;
  logic [3:0]  flags;
  logic        busy;

  logic        start4 = 1'b0;
  logic [1:0]  op4 = 2'b00;
  logic [3:0]  opA4 = '0;
  logic [3:0]  opB4 = '0;
  logic [3:0]  res14;
  logic [3:0]  res24;
  logic [3:0]  flags4;
  logic        busy4;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(start),
    .MCycleOp(op), .Operand1(opA), .Operand2(opB),
    .Result1(res1), .Result2(res2), .MFlags(flags),
    .Busy(busy)
  );

  mcycle_unit #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RESETn(RESETn), .Start(start4),
    .MCycleOp(op4), .Operand1(opA4), .Operand2(opB4),
    .Result1(res14), .Result2(res24), .MFlags(flags4),
    .Busy(busy4)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[13];

  task automatic check(
    input string       name,
    input logic [99:0] act,
    input logic [99:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Ends in the DONE cycle; operands are scrambled after the latch.
  task automatic run32(
    input  logic [1:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          cyc
  );
    @(negedge CLK);
    op = o; opA = a; opB = b; start = 1'b1;
    #1;
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      start = 1'b0;
      opA = $urandom; opB = $urandom; op = 2'($urandom);
      #1;
      if (!busy) break;
      cyc++;
    end
  endtask

  task automatic run4(
    input  logic [1:0] o,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output int         cyc
  );
    @(negedge CLK);
    op4 = o; opA4 = a; opB4 = b; start4 = 1'b1;
    #1;
    cyc = busy4 ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      start4 = 1'b0;
      opA4 = 4'($urandom); opB4 = 4'($urandom);
      #1;
      if (!busy4) break;
      cyc++;
    end
  endtask

  function automatic logic [11:0] model4(
    input logic [1:0] o,
    input logic [3:0] a,
    input logic [3:0] b
  );
    int sa, sb, p, q, r;
    logic [7:0] pb;
    logic [3:0] r1, r2;
    logic v;
    sa = (o[0] && a[3]) ? int'(a) - 16 : int'(a);
    sb = (o[0] && b[3]) ? int'(b) - 16 : int'(b);
    v = 1'b0;
    if (!o[1]) begin
      p = sa * sb;
      pb = p[7:0];
      return {pb[3:0], pb[7:4], pb[7], pb == 8'h00, 2'b00};
    end
    if (b == 4'h0) begin
      r1 = 4'hF; r2 = a; v = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      r1 = q[3:0]; r2 = r[3:0];
      if (o[0] && a == 4'h8 && b == 4'hF) v = 1'b1;
    end
    return {r1, r2, r1[3], r1 == 4'h0, 1'b0, v};
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [11:0] exp4;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000001, 32'hFFFFFFFE, 4'b1000};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007,
                 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000};
    vecs[2]  = '{2'b01, 32'h00000000, 32'h00012345,
                 32'h00000000, 32'h00000000, 4'b0100};
    vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000};
    vecs[4]  = '{2'b10, 32'd100, 32'd7,
                 32'd14, 32'd2, 4'b0000};
    vecs[5]  = '{2'b10, 32'd5, 32'd0,
                 32'hFFFFFFFF, 32'd5, 4'b1001};
    vecs[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 32'h00000000, 4'b1001};
    vecs[7]  = '{2'b00, 32'h00010000, 32'h00010000,
                 32'h00000000, 32'h00000001, 4'b0000};
    vecs[8]  = '{2'b11, 32'd7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 32'h00000001, 4'b1000};
    vecs[9]  = '{2'b10, 32'd0, 32'd5,
                 32'd0, 32'd0, 4'b0100};
    vecs[10] = '{2'b01, 32'h80000000, 32'h80000000,
                 32'h00000000, 32'h40000000, 4'b0000};
    vecs[11] = '{2'b11, 32'hFFFFFFFB, 32'd0,
                 32'hFFFFFFFF, 32'hFFFFFFFB, 4'b1001};
    vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'h10,
                 32'h0FFFFFFF, 32'h0000000F, 4'b0000};

    #12;
    check("reset outputs",
          100'({res1, res2, flags, busy}), 100'(0));
    @(negedge CLK);
    RESETn = 1'b1;

    foreach (vecs[i]) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d r1/r2/f/busy", i),
            100'({res1, res2, flags, 8'(cyc)}),
            100'({vecs[i].r1, vecs[i].r2, vecs[i].f, 8'd33}));
    end

    // Start pulse mid-COMPUTE with new operands is ignored.
    @(negedge CLK);
    op = 2'b00; opA = 32'd6; opB = 32'd7; start = 1'b1;
    #1;
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      start = (cyc == 5);
      if (start) begin
        op = 2'b10; opA = 32'd100; opB = 32'd7;
      end
      #1;
      if (!busy) break;
      cyc++;
    end
    start = 1'b0;
    check("ignored restart",
          100'({res1, res2, flags, 8'(cyc)}),
          100'({32'd42, 32'd0, 4'b0000, 8'd33}));
    @(negedge CLK);
    #1;
    check("idle after done",
          100'({busy, res1}), 100'({1'b0, 32'd42}));

    // Start held across DONE re-enters COMPUTE from IDLE.
    @(negedge CLK);
    op = 2'b01; opA = 32'hFFFFFFFD; opB = 32'd7; start = 1'b1;
    #1;
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      #1;
      if (!busy) break;
      cyc++;
    end
    check("held first op",
          100'({res1, res2, 8'(cyc), busy}),
          100'({32'hFFFFFFEB, 32'hFFFFFFFF, 8'd33, 1'b0}));
    op = 2'b10; opA = 32'd100; opB = 32'd7;
    @(negedge CLK);
    #1;
    check("held restart busy", 100'(busy), 100'(1));
    cyc = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      start = 1'b0;
      #1;
      if (!busy) break;
      cyc++;
    end
    check("held second op",
          100'({res1, res2, flags, 8'(cyc)}),
          100'({32'd14, 32'd2, 4'b0000, 8'd33}));

    // Async reset during COMPUTE discards the operation.
    @(negedge CLK);
    op = 2'b00; opA = 32'hFFFF; opB = 32'hFFFF; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    #1;
    RESETn = 1'b0;
    #1;
    check("async reset",
          100'({res1, res2, flags, busy}), 100'(0));
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (40) @(negedge CLK);
    #1;
    check("no done after reset",
          100'({res1, res2, flags, busy}), 100'(0));
    run32(2'b10, 32'd1000, 32'd10, cyc);
    check("op after reset",
          100'({res1, res2, flags, 8'(cyc)}),
          100'({32'd100, 32'd0, 4'b0000, 8'd33}));

    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run4(2'(o), 4'(a), 4'(b), cyc);
          exp4 = model4(2'(o), 4'(a), 4'(b));
          check($sformatf("w4 op%0d a%0d b%0d", o, a, b),
                100'({res14, res24, flags4, 8'(cyc)}),
                100'({exp4, 8'd5}));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
